// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch/decode/execute/writeback
// and drives datapath selects and write enables from the state register.
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | compute branch/jump target into ALUOut, pick path
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | store rs2 at ALUOut
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, conditionally load PC from ALUOut
// JAL      | PC <= target, ALU computes OldPC + 4 for link
// JALR1    | rs1 + imm into ALUOut
// JALR2    | PC <= ALUOut, ALU computes OldPC + 4 for link
// LUI      | write immediate to rd
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;
  logic   pc_write, ir_write, mem_write, reg_write;

  // Only func7[5] distinguishes SUB from ADD; the other bits are don't-care here.
  logic unused_func7;
  assign unused_func7 = &{1'b0, func7[6], func7[4:0]};

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR1;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(func3, func7[5]);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(func3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        case (func3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          3'b100:  pc_write = lt;
          3'b101:  pc_write = ~lt;
          default: pc_write = 1'b0;
        endcase
      end
      S_JAL, S_JALR2: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        reg_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_I, OP_JALR: ImmSrc = 3'b000;
      OP_SW:                ImmSrc = 3'b001;
      OP_BR:                ImmSrc = 3'b010;
      OP_JAL:               ImmSrc = 3'b011;
      OP_LUI:               ImmSrc = 3'b100;
      default:              ImmSrc = 3'b000;
    endcase
  end

  // FETCH is entered asynchronously on reset, so its enables must be masked.
  assign PCWrite  = pc_write  & rst;
  assign IRWrite  = ir_write  & rst;
  assign MemWrite = mem_write & rst;
  assign RegWrite = reg_write & rst;
  assign state    = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench for multi_cycle_controller: per-instruction state sequences
// and per-state output rules are modelled from the instruction-level behaviour.
module tb_multi_cycle_controller;

  logic       clk, rst;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       zero, lt;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       pcw, irw, mw, rw, adr;
    logic [1:0] sa, sb, rs;
    logic [2:0] alu, imm;
  } outs_t;

  int   exp_state;
  logic exp_valid = 1'b0;

  int obs_state[6], obs_pcw[6], obs_rw[6], obs_mw[6], obs_adr[6], obs_rs[6], obs_alu[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // States visited by one instruction, from FETCH until just before the next FETCH.
  function automatic int get_seq(input logic [6:0] op, output int s[6]);
    s = '{0, 1, 0, 0, 0, 0};
    case (op)
      7'b0000011: begin s[2] = 2; s[3] = 3;  s[4] = 4; return 5; end
      7'b0100011: begin s[2] = 2; s[3] = 5;  return 4; end
      7'b0110011: begin s[2] = 6; s[3] = 8;  return 4; end
      7'b0010011: begin s[2] = 7; s[3] = 8;  return 4; end
      7'b1100011: begin s[2] = 9; return 3; end
      7'b1101111: begin s[2] = 10; s[3] = 8; return 4; end
      7'b1100111: begin s[2] = 11; s[3] = 12; s[4] = 8; return 5; end
      7'b0110111: begin s[2] = 13; return 3; end
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] model_alu(input logic [2:0] f3, input logic sub);
    if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b100) return 3'b100;
    if (f3 == 3'b010) return 3'b101;
    return 3'b000;
  endfunction

  function automatic outs_t model(input int st, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z, input logic l);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.pcw = 1; o.irw = 1; o.sb = 2; o.rs = 2; end
      1:  begin o.sa = 1; o.sb = 1; end
      2:  begin o.sa = 2; o.sb = 1; end
      3:  o.adr = 1;
      4:  begin o.rs = 1; o.rw = 1; end
      5:  begin o.adr = 1; o.mw = 1; end
      6:  begin o.sa = 2; o.alu = model_alu(f3, f7[5]); end
      7:  begin o.sa = 2; o.sb = 1; o.alu = model_alu(f3, 1'b0); end
      8:  o.rw = 1;
      9:  begin
            o.sa = 2; o.alu = 3'b001;
            o.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) ||
                    (f3 == 3'b100 && l) || (f3 == 3'b101 && !l);
          end
      10, 12: begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      11: begin o.sa = 2; o.sb = 1; end
      13: begin o.rs = 3; o.rw = 1; end
      default: ;
    endcase
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: o.imm = 3'b000;
      7'b0100011: o.imm = 3'b001;
      7'b1100011: o.imm = 3'b010;
      7'b1101111: o.imm = 3'b011;
      7'b0110111: o.imm = 3'b100;
      default:    o.imm = 3'b000;
    endcase
    return o;
  endfunction

  // Single compare process: every meaningful cycle, DUT vs model.
  always @(negedge clk) begin
    if (exp_valid) begin
      outs_t e;
      e = model(exp_state, opcode, func3, func7, zero, lt);
      chk("state", int'(state), exp_state);
      chk("PCWrite", int'(PCWrite), int'(e.pcw));
      chk("IRWrite", int'(IRWrite), int'(e.irw));
      chk("MemWrite", int'(MemWrite), int'(e.mw));
      chk("RegWrite", int'(RegWrite), int'(e.rw));
      chk("AdrSrc", int'(AdrSrc), int'(e.adr));
      chk("ALUSrcA", int'(ALUSrcA), int'(e.sa));
      chk("ALUSrcB", int'(ALUSrcB), int'(e.sb));
      chk("ResultSrc", int'(ResultSrc), int'(e.rs));
      chk("ALUControl", int'(ALUControl), int'(e.alu));
      chk("ImmSrc", int'(ImmSrc), int'(e.imm));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_en"}, int'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
  endtask

  // Starts at posedge+1 in FETCH. zmode/lmode: 0/1 fixed, 2 random per cycle.
  // abort_at >= 0 pulls reset low mid-cycle in that step, then releases it.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int zmode, input int lmode, input int abort_at);
    int s[6];
    int n;
    n = get_seq(op, s);
    opcode = op; func3 = f3; func7 = f7;
    for (int i = 0; i < n; i++) begin
      exp_state = s[i];
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      lt   = (lmode == 2) ? 1'($urandom_range(0, 1)) : 1'(lmode);
      exp_valid = 1'b1;
      @(negedge clk);
      #1;
      obs_state[i] = int'(state); obs_pcw[i] = int'(PCWrite); obs_rw[i] = int'(RegWrite);
      obs_mw[i] = int'(MemWrite); obs_adr[i] = int'(AdrSrc); obs_rs[i] = int'(ResultSrc);
      obs_alu[i] = int'(ALUControl);
      if (i == abort_at) begin
        exp_valid = 1'b0;
        rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1 check_reset_outputs("held_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    outs_t m;
    rst = 1'b0; opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000; zero = 0; lt = 0;
    #2 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Model pins against hand-derived values.
    m = model(6, 7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    chk("pin_sub", int'(m.alu), 1);
    m = model(9, 7'b1100011, 3'b001, 7'b0, 1'b0, 1'b0);
    chk("pin_bne", int'(m.pcw), 1);
    m = model(0, 7'b1101111, 3'b0, 7'b0, 1'b0, 1'b0);
    chk("pin_fetch", int'({m.pcw, m.irw, m.sb, m.rs, m.imm}), 'b11_10_10_011);

    // R-type SUB
    run_instr(7'b0110011, 3'b000, 7'b0100000, 2, 2, -1);
    chk("sub_seq", obs_state[0]*1000 + obs_state[1]*100 + obs_state[2]*10 + obs_state[3], 168);
    chk("sub_next_state", int'(state), 0);
    chk("sub_alu", obs_alu[2], 1);
    chk("sub_rw", obs_rw[0] + obs_rw[1] + obs_rw[2] + 2*obs_rw[3], 2);

    // lw
    run_instr(7'b0000011, 3'b010, 7'b0, 2, 2, -1);
    chk("lw_seq", obs_state[2]*100 + obs_state[3]*10 + obs_state[4], 234);
    chk("lw_adr", obs_adr[3], 1);
    chk("lw_wb", obs_rs[4]*10 + obs_rw[4], 11);
    chk("lw_mw", obs_mw[0] + obs_mw[1] + obs_mw[2] + obs_mw[3] + obs_mw[4], 0);

    // Branches
    run_instr(7'b1100011, 3'b000, 7'b0, 1, 2, -1);
    chk("beq_taken", obs_pcw[2], 1);
    run_instr(7'b1100011, 3'b000, 7'b0, 0, 2, -1);
    chk("beq_not_taken", obs_pcw[2], 0);
    run_instr(7'b1100011, 3'b101, 7'b0, 2, 0, -1);
    chk("bge_taken", obs_pcw[2], 1);

    // jalr
    run_instr(7'b1100111, 3'b000, 7'b0, 2, 2, -1);
    chk("jalr_seq", obs_state[2]*100 + obs_state[3]*10 + obs_state[4], 11*100 + 12*10 + 8);
    chk("jalr_pcw", obs_pcw[0]*10000 + obs_pcw[1]*1000 + obs_pcw[2]*100 + obs_pcw[3]*10 + obs_pcw[4], 10010);
    chk("jalr_next_state", int'(state), 0);

    // sw aborted by reset in MEMWRITE, then an illegal opcode
    run_instr(7'b0100011, 3'b010, 7'b0, 2, 2, 3);
    chk("sw_abort_at", obs_state[3], 5);
    run_instr(7'b1111111, 3'b000, 7'b0, 2, 2, -1);
    chk("ill_seq", obs_state[0]*10 + obs_state[1], 1);
    chk("ill_decode_wr", obs_pcw[1] + obs_rw[1] + obs_mw[1], 0);
    chk("ill_next_state", int'(state), 0);

    // Randomized instruction stream with occasional mid-instruction resets.
    for (int k = 0; k < 400; k++) begin
      logic [6:0] op;
      int ab;
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, 3'($urandom), 7'($urandom), 2, 2, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  asynchronous reset, active-low.
REQ-003 opcode  input  7  instruction bits [6:0] from the instruction register.
REQ-004 func3  input  3  instruction bits [14:12].
REQ-005 func7  input  7  instruction bits [31:25].
REQ-006 zero, lt  input  1 each  ALU flags: result==0; signed A<B.
REQ-007 PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-008 AdrSrc  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 register A.
REQ-010 ALUSrcB  output  2  ALU B select: 00 register B, 01 immediate, 10 constant 4.
REQ-011 ResultSrc  output  2  result select: 00 ALUOut, 01 memory data register, 10 ALU result, 11 immediate.
REQ-012 ALUControl  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
REQ-013 ImmSrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-014 state  output  4  current state code, for debug.

Function
REQ-015 The state register SHALL be 4 bits and update on the rising edge of clk; all outputs SHALL be combinational from the state register and the inputs (Moore outputs, with branch-qualified PCWrite).
REQ-016 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR1 11, JALR2 12, LUI 13. Codes 14 and 15 SHALL return to FETCH on the next clock with all enables 0.
REQ-017 Outputs SHALL default to 0 in every state unless listed below.
REQ-018 ImmSrc SHALL be decoded from opcode in every state: lw/I-ALU/jalr -> I, sw -> S, branch -> B, jal -> J, lui -> U, other -> 000.
REQ-019 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; next state DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=ADD (target into ALUOut).
- Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR1; 0110111 -> LUI; any other -> FETCH.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-022 MEMREAD: AdrSrc=1; next state MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-024 MEMWRITE: AdrSrc=1, MemWrite=1; next state FETCH.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01. Both go to ALUWB next.
REQ-026 ALU decode in EXECR/EXECI:
- func3 000 -> ADD, or SUB when EXECR and func7[5]=1
- 111 AND; 110 OR; 100 XOR; 010 SLT
- other func3 -> ADD
REQ-027 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00; next state FETCH.
- PCWrite = (func3=000 & zero) | (001 & !zero) | (100 & lt) | (101 & !lt)
- other func3 -> PCWrite=0
REQ-029 JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-030 JALR1: ALUSrcA=10, ALUSrcB=01, ADD; next JALR2. JALR2: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-031 LUI: ResultSrc=11, RegWrite=1; next state FETCH.
REQ-032 Cycles per instruction SHALL be: lw 5, sw 4, R 4, I-ALU 4, branch 3, jal 4, jalr 5, lui 3, illegal opcode 2.

Reset
REQ-033 On rst=0 the state SHALL become FETCH immediately, regardless of clk.
REQ-034 While rst=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-035 Reset asserted in the middle of any instruction SHALL abandon that instruction; the first rising edge after rst=1 SHALL execute FETCH.

Verification
REQ-036 Release reset, opcode=0110011, func3=000, func7=0100000 -> state sequence 0,1,6,8,0; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB.
REQ-037 opcode=0000011 -> states 0,1,2,3,4; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4; MemWrite=0 throughout.
REQ-038 Branch cases, opcode=1100011:
- func3=000, zero=1 -> PCWrite=1 in BRANCH
- func3=000, zero=0 -> PCWrite=0
- func3=101, lt=0 -> PCWrite=1
REQ-039 opcode=1100111 -> states 0,1,11,12,8,0; PCWrite=1 in FETCH and JALR2 only.
REQ-040 rst pulled to 0 mid-cycle while in MEMWRITE -> state=0 and MemWrite=0 at once, without a clock edge; opcode=1111111 after release -> states 0,1,0 with no writes in DECODE.
